can_tx_queue: RTL
=================

CAN_TX_QUEUE -- requirements
Module: can_tx_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of message slots; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 wr_en  input  1  push request; one message per cycle.
REQ-005 wr_id  input  11  identifier of pushed message.
REQ-006 wr_data  input  8  payload byte of pushed message.
REQ-007 full  output  1  high when count == DEPTH.
REQ-008 empty  output  1  high when count == 0.
REQ-009 count  output  4  number of stored messages.
REQ-010 overflow  output  1  one-cycle pulse when a push is dropped.
REQ-011 id  output  11  identifier presented to the downstream CAN controller.
REQ-012 data  output  8  payload presented to the downstream CAN controller.
REQ-013 send  output  1  one-cycle start strobe to the downstream CAN controller.
REQ-014 busy  input  1  transmit-in-progress flag from the downstream CAN controller.

Function
REQ-015 Push accepted when wr_en=1 and full=0; wr_en=1 with full=1 shall drop the message and pulse overflow the next cycle, even if a pop occurs in the same cycle.
REQ-016 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE->LAUNCH when empty=0 and busy=0; IDLE shall hold while busy=1.
REQ-018 In LAUNCH the selected entry is popped, latched into id/data, and send=1 for exactly that one cycle; next state WAIT_BUSY.
REQ-019 id/data shall remain stable from LAUNCH until the FSM returns to IDLE.
REQ-020 WAIT_BUSY->WAIT_DONE on busy=1; if busy stays 0 for 16 cycles, the FSM shall return to IDLE (frame treated as lost, not re-queued).
REQ-021 WAIT_DONE->IDLE on busy=0.
REQ-022 Launch latency: a push into an empty queue with busy=0 shall produce send=1 two cycles after the push edge.
REQ-023 Back-to-back: after busy falls, the next send shall occur no earlier than two cycles later.
REQ-024 Simultaneous push and pop shall leave count unchanged; count shall never exceed DEPTH or underflow.
REQ-025 Pointers/slot indices shall wrap modulo DEPTH without loss or duplication.
REQ-026 A push into an empty queue in the same cycle the FSM samples IDLE shall not be launched until the following cycle.

Reset
REQ-027 On rst=1, asynchronously: state=IDLE, count=0, empty=1, full=0, overflow=0, send=0, id=0, data=0, all slots invalid.
REQ-028 Reset asserted mid-transmission shall discard all queued and in-flight messages; send shall not assert until at least one push after rst deasserts.

Configuration
REQ-029 Macro CAN_TX_PRIORITY_EN selects the pop order.
REQ-030 Without CAN_TX_PRIORITY_EN: strict FIFO order (oldest first).
REQ-031 With CAN_TX_PRIORITY_EN: LAUNCH pops the valid entry with the numerically lowest id (CAN arbitration priority); equal ids are resolved by lowest slot index; a push writes the lowest free slot.
REQ-032 Interface, latency and reset behaviour shall be identical in both builds.

Verification
REQ-033 Push (0x555, 0xCC) into empty queue with busy=0 -> send pulse 2 cycles later with id=0x555, data=0xCC; count returns to 0.
REQ-034 Push 5 messages back-to-back with DEPTH=4 while busy=1 -> full=1 after the 4th, overflow pulse on the 5th, count=4.
REQ-035 FIFO build: push ids 0x300, 0x100, 0x200; model busy 3 cycles after each send -> launches in order 0x300, 0x100, 0x200; in the CAN_TX_PRIORITY_EN build -> 0x100, 0x200, 0x300.
REQ-036 send with busy held 0 -> FSM returns to IDLE after 16 cycles and launches the next queued entry.
REQ-037 Assert rst during WAIT_DONE with 2 entries queued -> count=0, send=0 immediately; no further send after release.
REQ-038 Push and launch in the same cycle with count=2 -> count stays 2; no entry lost or duplicated.

Source files
------------

// File: rtl/can_tx_queue.sv
// can_tx_queue: DEPTH-slot CAN transmit queue with a launch/handshake FSM toward the CAN controller.
// Define CAN_TX_PRIORITY_EN to pop the lowest id first; the default build pops oldest first.
module can_tx_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [10:0] wr_id,
  input  logic [7:0]  wr_data,
  output logic        full,
  output logic        empty,
  output logic [3:0]  count,
  output logic        overflow,
  output logic [10:0] id,
  output logic [7:0]  data,
  output logic        send,
  input  logic        busy
);
  // state     | meaning
  // IDLE      | wait for a queued message while the controller is free
  // LAUNCH    | pop selected slot, latch id/data, strobe send
  // WAIT_BUSY | wait for controller to accept; 16-cycle timeout drops the frame
  // WAIT_DONE | frame in progress, wait for busy to fall

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] TIMEOUT = 4'd15;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t      state;
  logic [3:0]  timer;
  logic [10:0] slot_id   [DEPTH];
  logic [7:0]  slot_data [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic        push;
  logic        pop;

  assign full  = (count == 4'(DEPTH));
  assign empty = (count == 4'd0);
  assign push  = wr_en && !full;
  assign pop   = (state == LAUNCH);

`ifdef CAN_TX_PRIORITY_EN
  logic [DEPTH-1:0] slot_valid;
  logic             free_found;
  logic             sel_found;
  logic [10:0]      sel_id;

  // Strict less-than keeps the lowest slot index on equal ids.
  always_comb begin
    wr_idx     = '0;
    rd_idx     = '0;
    free_found = 1'b0;
    sel_found  = 1'b0;
    sel_id     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!slot_valid[i] && !free_found) begin
        wr_idx     = AW'(i);
        free_found = 1'b1;
      end
      if (slot_valid[i] && (!sel_found || slot_id[i] < sel_id)) begin
        rd_idx    = AW'(i);
        sel_id    = slot_id[i];
        sel_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
    end else begin
      if (pop)  slot_valid[rd_idx] <= 1'b0;
      if (push) slot_valid[wr_idx] <= 1'b1;
    end
  end
`else
  // DEPTH need not be a power of two, so pointers wrap explicitly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (push) wr_idx <= (wr_idx == AW'(DEPTH - 1)) ? '0 : wr_idx + AW'(1);
      if (pop)  rd_idx <= (rd_idx == AW'(DEPTH - 1)) ? '0 : rd_idx + AW'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      slot_id[wr_idx]   <= wr_id;
      slot_data[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 4'd0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= 4'd0;
      send  <= 1'b0;
      id    <= 11'd0;
      data  <= 8'd0;
    end else begin
      send <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty && !busy) state <= LAUNCH;
        end
        LAUNCH: begin
          id    <= slot_id[rd_idx];
          data  <= slot_data[rd_idx];
          send  <= 1'b1;
          timer <= TIMEOUT;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (busy)              state <= WAIT_DONE;
          else if (timer == 4'd0) state <= IDLE;
          else                   timer <= timer - 4'd1;
        end
        WAIT_DONE: begin
          if (!busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
